// File: rtl/cfu_pkg.sv
// rtl/cfu_pkg.sv - shared function codes, FSM states and int8 limits for cfu_requant
//
// Purpose: definitions shared by the requantization CFU and its helpers.
// Contents:
//   FN_*            7-bit function codes (function_id[9:3])
//   state_t         requant pipeline FSM states
//   INT8_MIN/MAX    default activation clamp bounds (16-bit signed)
package cfu_pkg;

    localparam logic [6:0] FN_REQUANT = 7'd0;
    localparam logic [6:0] FN_BIAS    = 7'd1;
    localparam logic [6:0] FN_MULT    = 7'd2;
    localparam logic [6:0] FN_SHIFT   = 7'd3;
    localparam logic [6:0] FN_OUTCFG  = 7'd4;
    localparam logic [6:0] FN_SATRD   = 7'd5;
    localparam logic [6:0] FN_SATCLR  = 7'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_MUL   = 3'd2,
        ST_ROUND = 3'd3,
        ST_CLAMP = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    localparam logic [15:0] INT8_MIN = 16'hFF80;
    localparam logic [15:0] INT8_MAX = 16'h007F;

endpackage

// File: rtl/requant_round.sv
// rtl/requant_round.sv - combinational SRDHM rounding and rounding divide-by-power-of-two
//
// Purpose: arithmetic helpers for the ROUND and CLAMP stages of cfu_requant.
// Ports:
//   i_prod   64-bit signed product x * mult
//   i_ovf    x and mult were both INT32_MIN (SRDHM saturates)
//   o_h      SRDHM result: (prod + nudge) / 2^31, truncated toward zero
//   i_h      SRDHM result registered by the ROUND stage
//   i_shift  right-shift amount 0..31
//   o_r      i_h divided by 2^shift, rounded half away from zero
module requant_round (
    input  logic [63:0] i_prod,
    input  logic        i_ovf,
    output logic [31:0] o_h,
    input  logic [31:0] i_h,
    input  logic [4:0]  i_shift,
    output logic [31:0] o_r
);

    logic signed [63:0] w_prod;
    logic signed [63:0] w_nudge;
    logic signed [63:0] w_sum;
    logic signed [63:0] w_quot;
    logic signed [31:0] w_hs;
    logic        [31:0] w_mask;
    logic        [31:0] w_rem;
    logic        [31:0] w_thr;
    logic               w_unused;

    always_comb begin
        w_prod  = $signed(i_prod);
        w_nudge = w_prod[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824;
        w_sum   = w_prod + w_nudge;
        // Arithmetic shift floors; bias negative values so the divide truncates toward zero.
        if (w_sum[63]) begin
            w_quot = (w_sum + 64'sd2147483647) >>> 31;
        end else begin
            w_quot = w_sum >>> 31;
        end
        o_h = i_ovf ? 32'h7FFF_FFFF : w_quot[31:0];

        w_hs   = $signed(i_h);
        w_mask = (32'd1 << i_shift) - 32'd1;
        w_rem  = i_h & w_mask;
        // Threshold grows by one for negatives so exact halves round away from zero.
        w_thr  = (w_mask >> 1) + {31'd0, i_h[31]};
        o_r    = $unsigned(w_hs >>> i_shift) + {31'd0, (w_rem > w_thr)};
    end

    assign w_unused = ^w_quot[63:32];

endmodule

// File: rtl/cfu_requant.sv
// rtl/cfu_requant.sv - int32 accumulator to int8 activation requantization CFU
//
// Purpose: bias add, SRDHM, RDBP, output offset and activation clamp behind the
// CPU custom-instruction cmd/rsp handshake. Per-channel bias/mult/shift tables
// are written by configuration commands.
// Optional feature macro: CFU_REQUANT_SATCNT_EN (clamp saturation counter,
// read with funct 5, cleared with funct 6).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake
//   cmd_payload_function_id[9:3]  function code; [2:0] ignored
//   cmd_payload_inputs_0/1        operands A / B
//   rsp_valid / rsp_ready         response handshake
//   rsp_payload_outputs_0         result
module cfu_requant #(
    parameter int NUM_CH = 64,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    import cfu_pkg::*;

    logic [31:0] r_bias_tab  [NUM_CH];
    logic [31:0] r_mult_tab  [NUM_CH];
    logic [4:0]  r_shift_tab [NUM_CH];

    state_t      r_state;
    logic        r_rsp_valid;
    logic [31:0] r_result;
    logic [31:0] r_out_offset;
    logic [15:0] r_act_min;
    logic [15:0] r_act_max;

    logic [31:0]     r_acc;
    logic [CH_W-1:0] r_ch;
    logic [31:0]     r_x;
    logic [31:0]     r_mult;
    logic [4:0]      r_shift;
    logic [63:0]     r_prod;
    logic            r_ovf;
    logic [31:0]     r_h;

`ifdef CFU_REQUANT_SATCNT_EN
    logic [31:0] r_satcnt;
`endif

    logic [6:0]         w_funct;
    logic               w_accept;
    logic [CH_W-1:0]    w_cfg_ch;
    logic [31:0]        w_h;
    logic [31:0]        w_r;
    logic signed [32:0] w_rp;
    logic signed [32:0] w_min;
    logic signed [32:0] w_max;
    logic               w_sat_hi;
    logic               w_sat_lo;
    logic               w_sat;
    logic [31:0]        w_clamped;
    logic               w_unused;

    assign w_funct   = cmd_payload_function_id[9:3];
    assign cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;
    assign w_accept  = cmd_valid && cmd_ready && !reset;
    assign w_cfg_ch  = cmd_payload_inputs_0[CH_W-1:0];

    assign rsp_valid             = r_rsp_valid;
    assign rsp_payload_outputs_0 = r_result;

    requant_round u_round (
        .i_prod  (r_prod),
        .i_ovf   (r_ovf),
        .o_h     (w_h),
        .i_h     (r_h),
        .i_shift (r_shift),
        .o_r     (w_r)
    );

    // Offset add is done at 33 bits so a large r plus offset cannot wrap past the clamp.
    always_comb begin
        w_rp      = $signed({w_r[31], w_r}) + $signed({r_out_offset[31], r_out_offset});
        w_min     = $signed({{17{r_act_min[15]}}, r_act_min});
        w_max     = $signed({{17{r_act_max[15]}}, r_act_max});
        w_sat_hi  = (w_rp > w_max);
        w_sat_lo  = (w_rp < w_min);
        w_sat     = w_sat_hi || w_sat_lo;
        // act_max wins when the bounds are inverted.
        if (w_sat_hi) begin
            w_clamped = w_max[31:0];
        end else if (w_sat_lo) begin
            w_clamped = w_min[31:0];
        end else begin
            w_clamped = w_rp[31:0];
        end
    end

    assign w_unused = ^{cmd_payload_function_id[2:0], w_rp[32], w_min[32], w_max[32], w_sat};

    // Channel tables survive reset; software reloads them explicitly.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            case (w_funct)
                FN_BIAS:  r_bias_tab[w_cfg_ch]  <= cmd_payload_inputs_1;
                FN_MULT:  r_mult_tab[w_cfg_ch]  <= cmd_payload_inputs_1;
                FN_SHIFT: r_shift_tab[w_cfg_ch] <= cmd_payload_inputs_1[4:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rsp_valid  <= 1'b0;
            r_result     <= 32'd0;
            r_out_offset <= 32'd0;
            r_act_min    <= INT8_MIN;
            r_act_max    <= INT8_MAX;
`ifdef CFU_REQUANT_SATCNT_EN
            r_satcnt     <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc <= cmd_payload_inputs_0;
                        r_ch  <= cmd_payload_inputs_1[CH_W-1:0];
                        case (w_funct)
                            FN_REQUANT: begin
                                r_state <= ST_BIAS;
                            end
                            FN_OUTCFG: begin
                                r_out_offset <= cmd_payload_inputs_0;
                                r_act_min    <= cmd_payload_inputs_1[15:0];
                                r_act_max    <= cmd_payload_inputs_1[31:16];
                                r_result     <= 32'd0;
                                r_state      <= ST_RESP;
                            end
`ifdef CFU_REQUANT_SATCNT_EN
                            FN_SATRD: begin
                                r_result <= r_satcnt;
                                r_state  <= ST_RESP;
                            end
                            FN_SATCLR: begin
                                r_satcnt <= 32'd0;
                                r_result <= 32'd0;
                                r_state  <= ST_RESP;
                            end
`endif
                            default: begin
                                r_result <= 32'd0;
                                r_state  <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_BIAS: begin
                    r_x     <= r_acc + r_bias_tab[r_ch];
                    r_mult  <= r_mult_tab[r_ch];
                    r_shift <= r_shift_tab[r_ch];
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    r_prod  <= $signed({{32{r_x[31]}}, r_x}) * $signed({{32{r_mult[31]}}, r_mult});
                    r_ovf   <= (r_x == 32'h8000_0000) && (r_mult == 32'h8000_0000);
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_h     <= w_h;
                    r_state <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    r_result    <= w_clamped;
                    r_rsp_valid <= 1'b1;
`ifdef CFU_REQUANT_SATCNT_EN
                    if (w_sat) begin
                        r_satcnt <= r_satcnt + 32'd1;
                    end
`endif
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // Config/unknown commands enter here with rsp_valid low and raise it one edge later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_requant.sv
// tb/tb_cfu_requant.sv - directed self-checking bench for cfu_requant
module tb_cfu_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] res;
    int          lat;
    logic [31:0] exp_sat;

    cfu_requant dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one command, measure edges from accept to rsp_valid, optionally
    // stall rsp_ready for 'hold' cycles, then retire the response.
    task automatic do_cmd(input string tag, input logic [6:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input int hold,
                          output logic [31:0] r, output int l);
        int waitc;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {fn, 3'b101};
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        l = 0;
        while (!rsp_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        r = rsp_payload_outputs_0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_payload"}, rsp_payload_outputs_0, r);
            check({tag, "_hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset                   = 1'b1;
        cmd_valid               = 1'b0;
        rsp_ready               = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0    = '0;
        cmd_payload_inputs_1    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_payload", rsp_payload_outputs_0, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // ch5: bias 0, mult 0.5, shift 0
        do_cmd("cfg_bias5", 7'd1, 32'd5, 32'd0, 0, res, lat);
        check("cfg_bias5_res", res, 32'd0);
        check("cfg_bias5_lat", lat, 32'd1);
        do_cmd("cfg_mult5", 7'd2, 32'd5, 32'h4000_0000, 0, res, lat);
        do_cmd("cfg_shift5", 7'd3, 32'd5, 32'd0, 0, res, lat);

        // reset while the requant is in MUL
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {7'd0, 3'b000};
        cmd_payload_inputs_0    = 32'hFFFF_FFFD;
        cmd_payload_inputs_1    = 32'd5;
        @(posedge clk); #1;          // accept -> BIAS
        cmd_valid = 1'b0;
        @(posedge clk); #1;          // -> MUL
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_quiet", {31'd0, rsp_valid}, 32'd0);

        // negative tie after reset, tables retained: acc=-3 -> -1
        do_cmd("neg_tie", 7'd0, 32'hFFFF_FFFD, 32'd5, 0, res, lat);
        check("neg_tie_res", res, 32'hFFFF_FFFF);
        check("neg_tie_lat", lat, 32'd4);

        // RDBP: shift 1, acc=-10 -> -3
        do_cmd("cfg_shift5b", 7'd3, 32'd5, 32'd1, 0, res, lat);
        do_cmd("rdbp", 7'd0, 32'hFFFF_FFF6, 32'd5, 0, res, lat);
        check("rdbp_res", res, 32'hFFFF_FFFD);

        // basic: ch3 via upper-bit-laden index 0x143, offset -128 -> 127 saturated
        do_cmd("cfg_bias3", 7'd1, 32'h0000_0103, 32'd24, 0, res, lat);
        do_cmd("cfg_mult3", 7'd2, 32'd3, 32'h4000_0000, 0, res, lat);
        do_cmd("cfg_shift3", 7'd3, 32'd3, 32'd1, 0, res, lat);
        do_cmd("cfg_out", 7'd4, 32'hFFFF_FF80, 32'h007F_FF80, 0, res, lat);
        check("cfg_out_lat", lat, 32'd1);
        do_cmd("basic", 7'd0, 32'd1000, 32'h0000_0143, 0, res, lat);
        check("basic_res", res, 32'd127);
        check("basic_lat", lat, 32'd4);

        // SRDHM saturation: INT32_MIN * INT32_MIN -> 127
        do_cmd("cfg_out0", 7'd4, 32'd0, 32'h007F_FF80, 0, res, lat);
        do_cmd("cfg_bias7", 7'd1, 32'd7, 32'd0, 0, res, lat);
        do_cmd("cfg_mult7", 7'd2, 32'd7, 32'h8000_0000, 0, res, lat);
        do_cmd("cfg_shift7", 7'd3, 32'd7, 32'd0, 0, res, lat);
        do_cmd("srdhm_sat", 7'd0, 32'h8000_0000, 32'd7, 0, res, lat);
        check("srdhm_sat_res", res, 32'd127);

        // response stall: rsp_ready low for 5 cycles
        do_cmd("hold", 7'd0, 32'hFFFF_FFF6, 32'd5, 5, res, lat);
        check("hold_res", res, 32'hFFFF_FFFD);

        // unknown function code
        do_cmd("unknown", 7'd9, 32'd5, 32'd123, 0, res, lat);
        check("unknown_res", res, 32'd0);
        check("unknown_lat", lat, 32'd1);

`ifdef CFU_REQUANT_SATCNT_EN
        exp_sat = 32'd2;
`else
        exp_sat = 32'd0;
`endif
        do_cmd("satrd", 7'd5, 32'd0, 32'd0, 0, res, lat);
        check("satrd_res", res, exp_sat);
        check("satrd_lat", lat, 32'd1);
        do_cmd("satclr", 7'd6, 32'd0, 32'd0, 0, res, lat);
        check("satclr_res", res, 32'd0);
        do_cmd("satrd2", 7'd5, 32'd0, 32'd0, 0, res, lat);
        check("satrd2_res", res, 32'd0);

        // lower clamp: min/max -5/5, acc=-100 on ch5 -> r=-25 -> -5
        do_cmd("cfg_out5", 7'd4, 32'd0, 32'h0005_FFFB, 0, res, lat);
        do_cmd("clamp_lo", 7'd0, 32'hFFFF_FF9C, 32'd5, 0, res, lat);
        check("clamp_lo_res", res, 32'hFFFF_FFFB);
        // upper clamp: acc=1000 on ch3 (offset 0) -> 256 -> 5
        do_cmd("clamp_hi", 7'd0, 32'd1000, 32'd3, 0, res, lat);
        check("clamp_hi_res", res, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
